// File: rtl/data_mem_port.sv
// data_mem_port: data-side memory port between the RV32I core load/store
// interface and N_CH synchronous memory channels. Decodes the channel from
// address[31:28], checks byte-enable legality, and runs a request/complete
// FSM with a configurable read latency and a one-cycle completion pulse.
module data_mem_port #(
   parameter int ADDR_W       = 18,
   parameter int N_CH         = 2,
   parameter int READ_LATENCY = 1
) (
   input  logic                 clock,
   input  logic                 sync_reset,
   input  logic                 memory_transaction,
   input  logic                 mem_write,
   input  logic [31:0]          address,
   input  logic [31:0]          data_in,
   input  logic [3:0]           byte_enablers,
   output logic [31:0]          read_data,
   output logic                 data_ready,
   output logic                 access_error,
   output logic                 busy,
   output logic [ADDR_W-1:0]    ch_address,
   output logic [31:0]          ch_data_out,
   output logic [3:0]           ch_byte_enablers,
   output logic [N_CH-1:0]      ch_write_enable,
   input  logic [N_CH*32-1:0]   ch_read_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state;
   logic              wr_q;
   logic              rej_q;
   logic [3:0]        ch_q;
   logic [1:0]        wait_cnt;
   logic              gap_q;

   logic [3:0]        req_ch;
   logic              be_legal;
   logic              req_rej;
   logic [N_CH-1:0]   req_we;
   logic [31:0]       sel_data;
   logic              enter_done;
   logic              unused_addr_bits;

   // Byte-offset and above-window address bits are deliberately not decoded.
   assign unused_addr_bits = ^address;

   // Decode the incoming request: channel, lane legality, rejection, write strobe.
   always_comb begin
      req_ch = address[31:28];
      case (byte_enablers)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
         default:                   be_legal = 1'b0;
      endcase
      req_rej = ({1'b0, req_ch} >= 5'(N_CH)) || !be_legal;
      req_we  = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (mem_write && !req_rej && req_ch == 4'(k))
            req_we[k] = 1'b1;
      end
   end

   // Select the latched channel's read lane and detect the final wait cycle.
   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (ch_q == 4'(k))
            sel_data = ch_read_data[k*32 +: 32];
      end
      enter_done = (state == ISSUE && READ_LATENCY == 1) ||
                   (state == WAIT  && wait_cnt == 2'd1);
   end

   // Request FSM with registered outputs; one forced idle cycle follows DONE.
   always_ff @(posedge clock) begin
      if (sync_reset) begin
         state            <= IDLE;
         read_data        <= '0;
         ch_address       <= '0;
         ch_data_out      <= '0;
         ch_byte_enablers <= '0;
         ch_write_enable  <= '0;
         data_ready       <= 1'b0;
         access_error     <= 1'b0;
         busy             <= 1'b0;
         wr_q             <= 1'b0;
         rej_q            <= 1'b0;
         ch_q             <= '0;
         wait_cnt         <= '0;
         gap_q            <= 1'b0;
      end else begin
         data_ready   <= 1'b0;
         access_error <= 1'b0;
         // The DONE transition is shared by ISSUE (latency 1) and WAIT.
         if (enter_done) begin
            state        <= DONE;
            data_ready   <= 1'b1;
            access_error <= rej_q;
            if (!wr_q)
               read_data <= rej_q ? '0 : sel_data;
         end
         case (state)
            IDLE: begin
               gap_q <= 1'b0;
               if (memory_transaction && !gap_q) begin
                  ch_address       <= address[ADDR_W+1:2];
                  ch_data_out      <= data_in;
                  ch_byte_enablers <= byte_enablers;
                  ch_write_enable  <= req_we;
                  wr_q             <= mem_write;
                  rej_q            <= req_rej;
                  ch_q             <= req_ch;
                  busy             <= 1'b1;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               ch_write_enable <= '0;
               if (!enter_done) begin
                  wait_cnt <= 2'(READ_LATENCY - 1);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 2'd1;
            end
            DONE: begin
               busy  <= 1'b0;
               gap_q <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Parametrised data-side memory port for the RV32I Harvard system. It sits between the core's load/store interface and N_CH synchronous memory channels: data RAM, MMIO and similar. It replaces the fixed one-cycle `data_ready` register with:

- a configurable-latency request/complete state machine;
- channel decode on the upper address bits;
- byte-enable legality checking with an error response.

## Interface

Parameters:

- `ADDR_W`, 18: word-address width presented to each channel.
- `N_CH`, 2: number of memory channels, 1..16.
- `READ_LATENCY`, 1: channel read latency in cycles, 1..4.

Ports:

- `clock` in 1: single clock, rising edge.
- `sync_reset` in 1: synchronous, active-high reset.
- `memory_transaction` in 1: core request strobe. The core holds it until `data_ready`.
- `mem_write` in 1: 1 = store, 0 = load.
- `address` in 32: byte address, i.e. the core's ALU result.
- `data_in` in 32: store data, already lane-positioned.
- `byte_enablers` in 4: store/load lane mask.
- `read_data` out 32: registered load data.
- `data_ready` out 1: one-cycle completion pulse.
- `access_error` out 1: qualifies `data_ready`; the access was rejected.
- `busy` out 1: high whenever the state is not IDLE.
- `ch_address` out ADDR_W: word address broadcast to all channels.
- `ch_data_out` out 32: store data broadcast.
- `ch_byte_enablers` out 4: lane mask broadcast.
- `ch_write_enable` out N_CH: one-hot write strobe.
- `ch_read_data` in N_CH*32: channel k occupies bits [32k+31:32k].

## Operation

- Channel select: ch = `address[31:28]`. A value of ch ≥ N_CH is unmapped.
- Word address: `address[ADDR_W+1:2]`, truncated. `address[1:0]` is ignored.
- Legal `byte_enablers` values: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value is illegal.
- A request is rejected if it is unmapped or has illegal lanes.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If `memory_transaction`=1, latch `address`, `data_in`, `byte_enablers`, `mem_write`, ch and reject into the request registers, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - The `ch_*` buses drive the latched values.
  - `ch_write_enable[ch]`=1 only if store and not rejected.
  - Load the wait counter with READ_LATENCY-1.
  - Go to WAIT if READ_LATENCY>1, else to DONE.
- WAIT: decrement the counter; go to DONE when it reaches 0. The `ch_*` buses hold their values and `ch_write_enable` is 0.
- DONE (one cycle):
  - `data_ready`=1.
  - `access_error` = reject.
  - Go to IDLE.
- `read_data` is captured at the ISSUE→… path such that it is valid in DONE:
  - It is the selected `ch_read_data` lane sampled READ_LATENCY cycles after ISSUE, for loads that are not rejected.
  - It is 0 for a rejected load.
  - It is unchanged for stores.
  - It holds its value until the next load completes.
- The block performs no lane shifting or sign extension; the core does that.
- `memory_transaction` is ignored outside IDLE. A request still held high in the DONE cycle is not re-accepted; it must be seen high in IDLE.
- A rejected store never asserts any `ch_write_enable` bit.

## Timing

- Reset values:
  - State = IDLE.
  - `read_data`, `ch_address`, `ch_data_out` = 0.
  - `ch_byte_enablers`, `ch_write_enable` = 0.
  - `data_ready`, `access_error`, `busy` = 0.
- Accept at edge E0, while in IDLE with the strobe high.
- ISSUE is the cycle after E0.
- `data_ready` is high exactly READ_LATENCY+1 cycles after the accept cycle. This gives 2 cycles for READ_LATENCY=1 and 5 cycles for READ_LATENCY=4.
- Stores and rejected requests use the same latency, so the core needs no access-type distinction.
- Back-to-back throughput: with the strobe held high, one access per READ_LATENCY+3 cycles. The idle gap after DONE is mandatory.
- `busy` is high from the cycle after accept through DONE inclusive.
- `sync_reset` asserted in any state:
  - At the next edge, return to IDLE with all reset values.
  - A pending write strobe is deasserted at that same edge.
  - No `data_ready` is produced for the aborted request.
- N_CH=1: every ch≠0 is unmapped.
- ADDR_W=30: the full word address is used.

## Test plan

- **Mapped load, READ_LATENCY=1.**
  - Stimulus: channel 0 returns 0xDEADBEEF; issue a load of `address`=0x0000_0010, BE=1111.
  - Required response: `ch_address`=4 in ISSUE; `data_ready`=1 and `read_data`=0xDEADBEEF 2 cycles after accept; `access_error`=0.
- **Store to channel 1.**
  - Stimulus: store `address`=0x1000_0008, `data_in`=0x0000_AB00, BE=0010.
  - Required response: `ch_write_enable`=10b for exactly one cycle; `ch_address`=2; `ch_byte_enablers`=0010; `read_data` unchanged.
- **Rejections, N_CH=2.**
  - Load at 0x3000_0000 → no write strobe, `read_data`=0, `access_error`=1 with `data_ready`.
  - Store with BE=0101 → no write strobe, `access_error`=1.
- **Latency sweep, READ_LATENCY=1..4.**
  - Stimulus: hold `memory_transaction` high for three back-to-back loads.
  - Required response: `data_ready` pulses are spaced READ_LATENCY+3 cycles apart; each pulse lasts one cycle; each load returns its own channel value.
- **Reset mid-access.**
  - Stimulus: assert `sync_reset` in the ISSUE cycle of a store.
  - Required response: `ch_write_enable`=0 from the next edge; no `data_ready`; `busy`=0; a new load accepted after reset completes normally.
